rx_pixel_sequencer: RTL

RX_PIXEL_SEQUENCER -- requirements
Module: rx_pixel_sequencer

---
 rtl/rx_pixel_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rx_pixel_sequencer.sv
// Assembles UART bytes into 24-bit RGB pixels framed by a sync byte, with a
// valid/ready pixel handshake, a per-frame pixel counter and a sticky error flag.
module rx_pixel_sequencer #(
    parameter int unsigned FRAME_PIXELS = 64,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        data_ready,
    input  logic [7:0]  rx_data,
    input  logic        framing_error,
    input  logic        overrun_error,
    output logic        data_read,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix_data,
    output logic        frame_done,
    output logic        err_flag,
    input  logic        clear_err,
    output logic [15:0] pix_count
);

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [15:0] FRAME_LAST = FRAME_PIXELS[15:0];

    state_t      state_r, state_s;
    logic [1:0]  byte_idx_r, byte_idx_s;
    logic [7:0]  red_r, green_r;
    logic [23:0] pix_data_r, pix_data_s;
    logic [7:0]  red_s, green_s;
    logic [15:0] pix_count_r, pix_count_s;
    logic        data_read_r, pix_valid_r, frame_done_r, err_flag_r, err_flag_s;
    logic        accept_s, fe_drop_s;

    // Next-state, byte capture, pixel counter and error flag decode
    always_comb begin
        state_s     = state_r;
        byte_idx_s  = byte_idx_r;
        red_s       = red_r;
        green_s     = green_r;
        pix_data_s  = pix_data_r;
        pix_count_s = pix_count_r;
        fe_drop_s   = 1'b0;
        // A byte is taken only when the previous consume pulse has finished
        accept_s    = data_ready && !data_read_r &&
                      ((state_r == ST_SYNC) || (state_r == ST_COLLECT));
        case (state_r)
            ST_SYNC: begin
                if (accept_s && (rx_data == SYNC_BYTE)) begin
                    state_s     = ST_COLLECT;
                    byte_idx_s  = 2'd0;
                    pix_count_s = 16'd0;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_COLLECT: begin
                if (accept_s && framing_error) begin
                    fe_drop_s  = 1'b1;
                    state_s    = ST_SYNC;
                    byte_idx_s = 2'd0;
                end else if (accept_s) begin
                    case (byte_idx_r)
                        2'd0: begin
                            red_s      = rx_data;
                            byte_idx_s = 2'd1;
                        end
                        2'd1: begin
                            green_s    = rx_data;
                            byte_idx_s = 2'd2;
                        end
                        default: begin
                            pix_data_s = {red_r, green_r, rx_data};
                            byte_idx_s = 2'd0;
                            state_s    = ST_PRESENT;
                        end
                    endcase
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_PRESENT: begin
                if (pix_ready) begin
                    pix_count_s = pix_count_r + 16'd1;
                    byte_idx_s  = 2'd0;
                    if ((pix_count_r + 16'd1) == FRAME_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else begin
                    state_s = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_s = ST_SYNC;
            end
            default: begin
                state_s    = ST_SYNC;
                byte_idx_s = 2'd0;
            end
        endcase

        // Set conditions take priority over the clear request
        if (overrun_error || fe_drop_s) begin
            err_flag_s = 1'b1;
        end else if (clear_err) begin
            err_flag_s = 1'b0;
        end else begin
            err_flag_s = err_flag_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= ST_SYNC;
            byte_idx_r   <= 2'd0;
            red_r        <= 8'd0;
            green_r      <= 8'd0;
            pix_data_r   <= 24'd0;
            pix_count_r  <= 16'd0;
            data_read_r  <= 1'b0;
            pix_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            err_flag_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            byte_idx_r   <= byte_idx_s;
            red_r        <= red_s;
            green_r      <= green_s;
            pix_data_r   <= pix_data_s;
            pix_count_r  <= pix_count_s;
            data_read_r  <= accept_s;
            pix_valid_r  <= (state_s == ST_PRESENT);
            frame_done_r <= (state_s == ST_DONE);
            err_flag_r   <= err_flag_s;
        end
    end

    assign data_read  = data_read_r;
    assign pix_valid  = pix_valid_r;
    assign pix_data   = pix_data_r;
    assign frame_done = frame_done_r;
    assign err_flag   = err_flag_r;
    assign pix_count  = pix_count_r;

endmodule
